// File: rtl/j2_muldiv_unit.sv
// j2_muldiv_unit: multi-cycle multiply/divide coprocessor for the j2 core.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle;
// a single FIX cycle applies signs and loads the result register.
// Ports:
//   clk, resetq       clock, async active-low reset
//   flush             synchronous abort to IDLE (result kept)
//   start, op         request and opcode (MUL/MULHU/MULH/-/DIVU/REMU/DIV/REM)
//   operand_n/_t      N (dividend / multiplicand), T (divisor / multiplier)
//   busy, done        busy in RUN/FIX; done is a one-cycle pulse
//   result            registered result, held until the next accepted start
//   div_by_zero       with done: DIV*/REM* issued with T == 0
module j2_muldiv_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             flush,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_n,
    input  logic [WIDTH-1:0] operand_t,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [2:0] OpMulh = 3'b010;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    // acc holds {hi, lo}: product {hi, lo}, or {remainder, quotient/dividend}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   numer_q, numer_d;  // raw N, the remainder on divide by zero
    logic               neg_q, neg_d;      // product / quotient must be negated
    logic               neg_rem_q, neg_rem_d;
    logic               tzero_q, tzero_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               dbz_q, dbz_d;

    // Operand conditioning at accept time.
    logic             is_signed, n_neg, t_neg;
    logic [WIDTH-1:0] n_mag, t_mag;

    assign is_signed = (op == OpMulh) || (op[2] && op[1]);
    assign n_neg     = is_signed && operand_n[WIDTH-1];
    assign t_neg     = is_signed && operand_t[WIDTH-1];
    assign n_mag     = n_neg ? -operand_n : operand_n;
    assign t_mag     = t_neg ? -operand_t : operand_t;

    // One multiply step: conditional add into the high half, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? dsr_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step; rem_diff[WIDTH] is the borrow.
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dsr_q};
    assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign fixup. High half of a negated 2W product: ~hi plus the carry out of ~lo + 1.
    logic             lo_zero;
    logic [WIDTH-1:0] mulh_hi, quot, rem, fix_result;

    assign lo_zero = ~|acc_q[WIDTH-1:0];
    assign mulh_hi = neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, lo_zero})
                           : acc_q[2*WIDTH-1:WIDTH];
    assign quot    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_result = '0;
        case (op_q)
            3'b000:         fix_result = acc_q[WIDTH-1:0];
            3'b001:         fix_result = acc_q[2*WIDTH-1:WIDTH];
            3'b010:         fix_result = mulh_hi;
            3'b100, 3'b110: fix_result = tzero_q ? {WIDTH{1'b1}} : quot;
            3'b101, 3'b111: fix_result = tzero_q ? numer_q : rem;
            default:        fix_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        dsr_d     = dsr_q;
        numer_d   = numer_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        tzero_d   = tzero_q;
        result_d  = result_q;
        dbz_d     = dbz_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d   = StRun;
                        cnt_d     = '0;
                        op_d      = op;
                        numer_d   = operand_n;
                        tzero_d   = (operand_t == '0);
                        neg_d     = n_neg ^ t_neg;
                        neg_rem_d = n_neg;
                        dbz_d     = 1'b0;
                        if (op[2]) begin
                            acc_d = {{WIDTH{1'b0}}, n_mag};
                            dsr_d = t_mag;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, t_mag};
                            dsr_d = n_mag;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StRun: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StFix: begin
                    result_d = fix_result;
                    dbz_d    = op_q[2] && tzero_q;
                    state_d  = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            dsr_q     <= '0;
            numer_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            tzero_q   <= 1'b0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            dsr_q     <= dsr_d;
            numer_q   <= numer_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            tzero_q   <= tzero_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun) || (state_q == StFix);
    assign done        = (state_q == StDone);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_j2_muldiv_unit.sv
// Self-checking bench for j2_muldiv_unit (WIDTH = 16): directed cases, handshake,
// reset/flush aborts, and randomized ops against an arithmetic reference model.
module tb_j2_muldiv_unit;

    localparam int W = 16;
    localparam int LAT = 17;

    logic         clk;
    logic         resetq;
    logic         flush;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] operand_n;
    logic [W-1:0] operand_t;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    j2_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .resetq      (resetq),
        .flush       (flush),
        .start       (start),
        .op          (op),
        .operand_n   (operand_n),
        .operand_t   (operand_t),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {div_by_zero, result} from plain integer arithmetic.
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] n,
                                         input logic [W-1:0] t);
        longint       up;
        longint       sp;
        int           sn;
        int           st;
        logic [W-1:0] r;
        up = longint'(n) * longint'(t);
        sn = int'($signed(n));
        st = int'($signed(t));
        sp = longint'(sn) * longint'(st);
        r  = '0;
        case (o)
            3'd0: r = up[15:0];
            3'd1: r = up[31:16];
            3'd2: r = sp[31:16];
            3'd3: r = '0;
            3'd4: r = (t == 0) ? 16'hFFFF : n / t;
            3'd5: r = (t == 0) ? n : n % t;
            3'd6: r = (t == 0) ? 16'hFFFF : 16'(sn / st);
            default: r = (t == 0) ? n : 16'(sn % st);
        endcase
        return {(o[2] && t == 0), r};
    endfunction

    // Wait for done with a bound; cyc = edges after accept, or -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Count done pulses over n cycles.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    // Present a request now, let the next edge accept it, then scramble the inputs.
    task automatic accept(input logic [2:0] o, input logic [W-1:0] n, input logic [W-1:0] t);
        op        = o;
        operand_n = n;
        operand_t = t;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op        = 3'($urandom);
        operand_n = 16'($urandom);
        operand_t = 16'($urandom);
        check_eq("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Full op: accept, wait, check latency/result/flag. Returns in the done cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] n,
                          input logic [W-1:0] t);
        int         cyc;
        logic [W:0] exp;
        exp = model(o, n, t);
        accept(o, n, t);
        wait_done(cyc);
        check_eq({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check_eq({tag, "_result"}, 32'(result), 32'(exp[W-1:0]));
        check_eq({tag, "_dbz"}, 32'(div_by_zero), 32'(exp[W]));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] specials [5];
        specials[0] = 16'h0000;
        specials[1] = 16'h0001;
        specials[2] = 16'hFFFF;
        specials[3] = 16'h8000;
        specials[4] = 16'h7FFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    initial begin
        int         cyc;
        int         cnt;
        logic [W:0] exp;
        logic [W-1:0] held;

        resetq    = 1'b0;
        flush     = 1'b0;
        start     = 1'b0;
        op        = '0;
        operand_n = '0;
        operand_t = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_result", 32'(result), 32'd0);
        check_eq("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);

        // Directed arithmetic.
        run_op("mul", 3'd0, 16'h1234, 16'h0010);
        check_eq("mul_value", 32'(result), 32'h2340);
        @(posedge clk);
        #1;
        check_eq("done_pulse_width", 32'(done), 32'd0);
        check_eq("idle_not_busy", 32'(busy), 32'd0);
        run_op("mulhu", 3'd1, 16'hFFFF, 16'hFFFF);
        check_eq("mulhu_value", 32'(result), 32'hFFFE);
        run_op("mulh", 3'd2, 16'hFFFF, 16'h0002);
        check_eq("mulh_value", 32'(result), 32'hFFFF);
        run_op("divu", 3'd4, 16'd100, 16'd7);
        check_eq("divu_value", 32'(result), 32'h000E);
        run_op("remu", 3'd5, 16'd100, 16'd7);
        check_eq("remu_value", 32'(result), 32'h0002);
        run_op("div", 3'd6, 16'hFFF9, 16'h0002);
        check_eq("div_value", 32'(result), 32'hFFFD);
        run_op("rem", 3'd7, 16'hFFF9, 16'h0002);
        check_eq("rem_value", 32'(result), 32'hFFFF);
        run_op("divu0", 3'd4, 16'h1234, 16'h0000);
        check_eq("divu0_value", 32'(result), 32'hFFFF);
        check_eq("divu0_flag", 32'(div_by_zero), 32'd1);
        run_op("remu0", 3'd5, 16'h1234, 16'h0000);
        check_eq("remu0_value", 32'(result), 32'h1234);
        run_op("mul_after_dbz", 3'd0, 16'h0003, 16'h0005);
        check_eq("mul_after_dbz_flag", 32'(div_by_zero), 32'd0);
        run_op("div_ovf", 3'd6, 16'h8000, 16'hFFFF);
        check_eq("div_ovf_value", 32'(result), 32'h8000);
        run_op("rem_ovf", 3'd7, 16'h8000, 16'hFFFF);
        check_eq("rem_ovf_value", 32'(result), 32'h0000);
        run_op("rsvd", 3'd3, 16'h1234, 16'h5678);
        check_eq("rsvd_value", 32'(result), 32'h0000);

        // Start during RUN is ignored.
        @(negedge clk);
        exp = model(3'd0, 16'h0101, 16'h0003);
        accept(3'd0, 16'h0101, 16'h0003);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) begin
                op = 3'd4; operand_n = 16'h0FFF; operand_t = 16'h0002; start = 1'b1;
            end
            if (c == 6) start = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
        end
        check_eq("ignored_start_latency", 32'(cyc), 32'(LAT));
        check_eq("ignored_start_result", 32'(result), 32'(exp[W-1:0]));
        count_done(25, cnt);
        check_eq("ignored_start_single_done", 32'(cnt), 32'd0);

        // Back-to-back issue from the DONE cycle.
        @(negedge clk);
        run_op("b2b_first", 3'd1, 16'h4000, 16'h0008);
        run_op("b2b_second", 3'd5, 16'h0400, 16'h0007);

        // Reset mid-RUN.
        @(negedge clk);
        accept(3'd0, 16'h0011, 16'h0011);
        repeat (5) @(posedge clk);
        @(negedge clk);
        resetq = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        count_done(25, cnt);
        check_eq("rst_no_done", 32'(cnt), 32'd0);
        check_eq("rst_idle", 32'(busy), 32'd0);

        // Flush mid-RUN keeps the prior result.
        @(negedge clk);
        run_op("pre_flush", 3'd0, 16'h0007, 16'h0009);
        held = result;
        @(negedge clk);
        accept(3'd4, 16'h7777, 16'h0003);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_result_kept", 32'(result), 32'(held));
        @(negedge clk);
        flush = 1'b0;
        count_done(25, cnt);
        check_eq("flush_no_done", 32'(cnt), 32'd0);

        // Flush beats start in the DONE cycle.
        @(negedge clk);
        run_op("pre_flush2", 3'd0, 16'h0002, 16'h0002);
        flush = 1'b1;
        start = 1'b1;
        op = 3'd0; operand_n = 16'h0003; operand_t = 16'h0003;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check_eq("flush_beats_start_busy", 32'(busy), 32'd0);
        count_done(25, cnt);
        check_eq("flush_beats_start_no_done", 32'(cnt), 32'd0);
        check_eq("flush_beats_start_result", 32'(result), 32'h0004);

        // Randomized ops, sometimes issued back-to-back from DONE.
        for (int i = 0; i < 250; i++) begin
            logic [2:0]   o;
            logic [W-1:0] n;
            logic [W-1:0] t;
            o = 3'($urandom_range(0, 7));
            n = pick_operand();
            t = pick_operand();
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            run_op("rand", o, n, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
